// File: rtl/crack_job_scheduler.sv
// Job-level controller for the hash-search array: splits one job's keyspace by first-character
// index across NUM_LANES generator lanes, granted round-robin, and reports a single result.
module crack_job_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [7:0]           job_num_chars,
  input  logic [7:0]           job_len,
  input  logic [127:0]         job_goal,
  input  logic                 abort,
  output logic [7:0]           cfg_num_chars,
  output logic [7:0]           cfg_len,
  output logic [127:0]         cfg_goal,
  output logic [7:0]           lane_prefix,
  output logic [NUM_LANES-1:0] lane_program,
  output logic [NUM_LANES-1:0] lane_initiate,
  output logic                 lane_abort,
  input  logic [NUM_LANES-1:0] lane_done,
  input  logic [NUM_LANES-1:0] lane_found,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_found,
  output logic                 res_aborted,
  output logic [LANE_W-1:0]    res_lane,
  output logic [7:0]           res_prefix
);

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

  state_t               state;
  logic [NUM_LANES-1:0] busy;
  logic [7:0]           next_prefix;
  logic [LANE_W-1:0]    rr;
  logic [LANE_W-1:0]    grant_lane;
  logic                 grant_active;
  logic [1:0]           phase;
  logic [7:0]           slot [NUM_LANES];

  logic [NUM_LANES-1:0] busy_after_done;
  logic [NUM_LANES-1:0] found_hit;
  logic                 found_any;
  logic [LANE_W-1:0]    found_lane;
  logic                 pick_ok;
  logic [LANE_W-1:0]    pick_lane;
  logic [LANE_W-1:0]    scan_lane;
  logic                 can_grant;

  function automatic logic [NUM_LANES-1:0] lane_bit(input logic [LANE_W-1:0] l);
    logic [NUM_LANES-1:0] v;
    v    = '0;
    v[l] = 1'b1;
    return v;
  endfunction

  assign busy_after_done = busy & ~lane_done;
  assign found_hit       = lane_found & busy;
  assign can_grant       = pick_ok && (next_prefix < cfg_num_chars);

  // Lowest-index busy lane reporting a match wins
  always_comb begin
    found_any  = 1'b0;
    found_lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (found_hit[i]) begin
        found_any  = 1'b1;
        found_lane = LANE_W'(i);
      end
    end
  end

  // First idle lane at or after the round-robin pointer; lanes finishing this cycle count as idle
  always_comb begin
    pick_ok   = 1'b0;
    pick_lane = '0;
    scan_lane = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      scan_lane = LANE_W'((int'(rr) + k) % NUM_LANES);
      if (!busy_after_done[scan_lane]) begin
        pick_ok   = 1'b1;
        pick_lane = scan_lane;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      job_ready     <= 1'b0;
      cfg_num_chars <= '0;
      cfg_len       <= '0;
      cfg_goal      <= '0;
      lane_prefix   <= '0;
      lane_program  <= '0;
      lane_initiate <= '0;
      lane_abort    <= 1'b0;
      res_valid     <= 1'b0;
      res_found     <= 1'b0;
      res_aborted   <= 1'b0;
      res_lane      <= '0;
      res_prefix    <= '0;
      busy          <= '0;
      next_prefix   <= '0;
      rr            <= '0;
      grant_lane    <= '0;
      grant_active  <= 1'b0;
      phase         <= '0;
      for (int i = 0; i < NUM_LANES; i++) slot[i] <= '0;
    end else begin
      lane_abort    <= 1'b0;
      lane_initiate <= '0;
      unique case (state)
        IDLE: begin
          job_ready <= 1'b1;
          if (job_valid && job_ready) begin
            job_ready     <= 1'b0;
            cfg_num_chars <= job_num_chars;
            cfg_len       <= job_len;
            cfg_goal      <= job_goal;
            next_prefix   <= '0;
            res_found     <= 1'b0;
            res_aborted   <= 1'b0;
            if (job_num_chars == 8'd0 || job_len == 8'd0) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              // The first grant starts on the accept edge so its initiate lands 3 cycles later
              state        <= DISPATCH;
              grant_active <= 1'b1;
              grant_lane   <= pick_lane;
              phase        <= 2'd0;
              lane_program <= lane_bit(pick_lane);
              lane_prefix  <= 8'd0;
            end
          end
        end

        DISPATCH, DRAIN: begin
          if (abort) begin
            lane_abort   <= 1'b1;
            lane_program <= '0;
            busy         <= '0;
            grant_active <= 1'b0;
            state        <= DONE;
            res_valid    <= 1'b1;
            res_aborted  <= 1'b1;
            res_found    <= 1'b0;
          end else if (found_any) begin
            lane_abort   <= 1'b1;
            lane_program <= '0;
            busy         <= '0;
            grant_active <= 1'b0;
            state        <= DONE;
            res_valid    <= 1'b1;
            res_found    <= 1'b1;
            res_aborted  <= 1'b0;
            res_lane     <= found_lane;
            res_prefix   <= slot[found_lane];
          end else begin
            if (grant_active && phase == 2'd1) begin
              busy <= busy_after_done | lane_bit(grant_lane);
            end else begin
              busy <= busy_after_done;
            end

            if (grant_active && phase == 2'd0) begin
              phase <= 2'd1;
            end else if (grant_active && phase == 2'd1) begin
              phase              <= 2'd2;
              lane_program       <= '0;
              lane_initiate      <= lane_bit(grant_lane);
              slot[grant_lane]   <= lane_prefix;
              next_prefix        <= next_prefix + 8'd1;
              rr                 <= LANE_W'((int'(grant_lane) + 1) % NUM_LANES);
            end else if (can_grant) begin
              // Back-to-back grant: programming starts in the cycle right after the initiate
              state        <= DISPATCH;
              grant_active <= 1'b1;
              grant_lane   <= pick_lane;
              phase        <= 2'd0;
              lane_program <= lane_bit(pick_lane);
              lane_prefix  <= next_prefix;
            end else begin
              grant_active <= 1'b0;
              if (next_prefix == cfg_num_chars) begin
                if (busy_after_done == '0) begin
                  state       <= DONE;
                  res_valid   <= 1'b1;
                  res_found   <= 1'b0;
                  res_aborted <= 1'b0;
                end else begin
                  state <= DRAIN;
                end
              end
            end
          end
        end

        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
